apb_regfile_slave: RTL
======================

Name: apb_regfile_slave

Overview:
APB3 completer (responder) holding NUM_REGS 32-bit read/write registers at a configurable base address. It answers transfers from the team's APB initiator. Over the existing minimal slave it adds programmable wait states, address decode with PSLVERR on bad accesses, and a per-register write strobe output for downstream logic.

Parameters:
NUM_REGS, 8, number of 32-bit registers (1..16); register i sits at byte offset 4*i.
BASE_ADDR, 32'h0000_1000, byte address of register 0; must be 64-byte aligned.
WAIT_CYCLES, 1, PREADY-low cycles inserted in each access phase (0..15).

Ports:
pclk  in  1  APB clock.
preset_n  in  1  Asynchronous active-low reset.
psel  in  1  Select.
penable  in  1  Enable (access phase).
paddr  in  32  Byte address.
pwrite  in  1  1 = write, 0 = read.
pwdata  in  32  Write data.
pstrb  in  4  Byte lanes; used only when APB_PSTRB_EN is defined, otherwise ignored.
prdata  out  32  Read data.
pready  out  1  Transfer complete.
pslverr  out  1  Transfer error; valid only while pready=1.
reg_wr_o  out  NUM_REGS  One-hot pulse, one cycle, on the clock edge a register is written.

Behaviour:
- Reset: preset_n, asynchronous, active-low; clock pclk.
  - All registers = 0, FSM = IDLE, wait counter = 0.
  - Outputs during reset: prdata=0, pready=0, pslverr=0, reg_wr_o=0.
- FSM states: IDLE, ACCESS.
- IDLE to ACCESS: when psel=1 and penable=0 (setup phase).
  - Capture paddr, pwrite, and the decode result.
  - Load counter with WAIT_CYCLES.
- ACCESS with counter != 0:
  - pready=0; counter decrements each cycle.
  - pwdata and pstrb are not sampled.
- ACCESS with counter == 0:
  - pready=1 combinationally.
  - A write commits at the next rising edge; state returns to IDLE on that edge.
  - WAIT_CYCLES=0 gives zero-wait: pready=1 in the first access cycle.
- Access-phase latency: WAIT_CYCLES+1 cycles with penable=1.
- Decode:
  - valid = (paddr[1:0]==0) and (paddr-BASE_ADDR) < 4*NUM_REGS, unsigned compare.
  - Index = (paddr-BASE_ADDR)>>2.
  - Addresses below BASE_ADDR wrap to a large offset and are therefore invalid.
- Invalid address:
  - pslverr=1 with pready=1.
  - Write suppressed, reg_wr_o stays 0, prdata=0.
- Read data:
  - prdata = register[index] only while pready=1, pwrite=0 and valid; otherwise 0.
  - Registers are read through the combinational mux. No read side effects.
- Write:
  - register[index] <= pwdata on the edge where pready=1 and valid.
  - reg_wr_o[index]=1 for exactly the following cycle.
- Master abort (psel drops while in ACCESS): return to IDLE at the next edge, no write, no pulse.
- Protocol violation (psel=1 and penable=1 while in IDLE, i.e. no setup phase):
  - Same cycle: pready=1, pslverr=1, no write, prdata=0.
  - This is required so the initiator never hangs.
- Back-to-back transfers:
  - A setup phase in the cycle right after completion is accepted normally, since the FSM is already in IDLE.
- paddr/pwrite changing during ACCESS: ignored; the captured setup-phase values are used.
- Reset asserted mid-access: transfer dropped, no partial write, all state to reset values.

Optional Feature:
APB_PSTRB_EN
- Defined: a write updates only byte lanes with pstrb[k]=1 (bits 8k+7:8k).
  - pstrb=4'b0000 on a valid write: no data change, pslverr=0, reg_wr_o still pulses.
  - Reads ignore pstrb.
- Undefined: pstrb is ignored and every write updates all 32 bits.

Test Plan:
1. Reset, WAIT_CYCLES=1 → read every register: each returns 0 with pslverr=0; pready low for 1 access cycle then high.
2. Write 32'hDEAD_BEEF to 0x1008, then read 0x1008 → read returns 32'hDEAD_BEEF; reg_wr_o=8'b0000_0100 for exactly one cycle; other registers stay 0.
3. Write to 0x1020 (out of range), 0x1002 (misaligned) and 0x0FFC (below base) → each gives pready=1 with pslverr=1, no register changes, reg_wr_o=0.
4. WAIT_CYCLES=0 → back-to-back write then read of 0x1004 with no idle cycle: both complete in one access cycle each; read returns the written value.
5. Master abort: setup for a write of 32'h1234_5678 to 0x1000, drop psel in the first wait cycle → register 0 unchanged; next transfer completes normally. Second check: psel=1, penable=1 from IDLE → pready=1, pslverr=1 same cycle.
6. With APB_PSTRB_EN: write 32'hFFFF_FFFF to 0x1000, then 32'h0000_0000 with pstrb=4'b0101 → register 0 reads 32'hFF00_FF00. Without the macro the same sequence reads 32'h0000_0000.

Source files
------------

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_regfile_slave
// Description : APB3 completer with NUM_REGS 32-bit read/write registers at
//               BASE_ADDR. It adds programmable wait states, address decode
//               with PSLVERR on bad accesses, and a one-cycle one-hot write
//               strobe per register for downstream logic.
// Build option: APB_PSTRB_EN - when defined, writes honour pstrb byte lanes.
//               When undefined, pstrb is ignored and every write updates all
//               32 bits.
// Parameters  : NUM_REGS    - register count (1..16), register i at 4*i
//               BASE_ADDR   - byte address of register 0 (64-byte aligned)
//               WAIT_CYCLES - PREADY-low cycles per access phase (0..15)
// Ports       : pclk      in   APB clock
//               preset_n  in   asynchronous active-low reset
//               psel      in   select
//               penable   in   access phase
//               paddr     in   byte address [31:0]
//               pwrite    in   1 = write, 0 = read
//               pwdata    in   write data [31:0]
//               pstrb     in   byte lanes [3:0] (APB_PSTRB_EN only)
//               prdata    out  read data [31:0], 0 unless a valid read completes
//               pready    out  transfer complete
//               pslverr   out  transfer error, qualified by pready
//               reg_wr_o  out  one-hot pulse in the cycle after a write
// Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile_slave #(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                pclk,
    input  logic                preset_n,
    input  logic                psel,
    input  logic                penable,
    input  logic [31:0]         paddr,
    input  logic                pwrite,
    input  logic [31:0]         pwdata,
    input  logic [3:0]          pstrb,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [NUM_REGS-1:0] reg_wr_o
);

    localparam int unsigned c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] c_SPAN  = 32'(4 * NUM_REGS);
    localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

    localparam logic [0:0]  c_ST_IDLE   = 1'b0;
    localparam logic [0:0]  c_ST_ACCESS = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [3:0]          r_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_write;
    logic                r_valid;
    logic [31:0]         r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_pulse;

    // ------------------------------------------------------------------------
    // Address decode. The subtraction is unsigned, so addresses below the
    // base wrap to a huge offset and fail the range compare on their own.
    // ------------------------------------------------------------------------
    logic [31:0]        w_off;
    logic               w_dec_valid;
    logic [c_IDX_W-1:0] w_dec_idx;

    assign w_off       = paddr - BASE_ADDR;
    assign w_dec_valid = (paddr[1:0] == 2'b00) && (w_off < c_SPAN);
    assign w_dec_idx   = w_off[c_IDX_W+1:2];

    // ------------------------------------------------------------------------
    // Transfer events
    // ------------------------------------------------------------------------
    logic w_setup;
    logic w_proto_err;
    logic w_done;
    logic w_commit;

    assign w_setup     = (r_state == c_ST_IDLE) && psel && !penable;
    // Enable without a preceding setup phase: answer immediately with an
    // error so the initiator cannot hang waiting for pready.
    assign w_proto_err = (r_state == c_ST_IDLE) && psel && penable;
    assign w_done      = (r_state == c_ST_ACCESS) && psel && (r_cnt == 4'd0);
    assign w_commit    = w_done && r_write && r_valid;

    // Byte-lane enables for the write path
    logic [3:0] w_be;
`ifdef APB_PSTRB_EN
    assign w_be = pstrb;
`else
    assign w_be = 4'hF;
    logic w_unused_pstrb;
    assign w_unused_pstrb = &{1'b0, pstrb};
`endif

    // Register select decoded from the captured index; used by both the
    // read mux and the write path so an index beyond NUM_REGS selects nothing.
    logic [NUM_REGS-1:0] w_sel;
    logic [31:0]         w_rd_mux;

    always_comb begin
        w_sel    = '0;
        w_rd_mux = 32'd0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_rd_mux = r_regs[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                // Leave on completion, or at once if the initiator aborts
                if (!psel || (r_cnt == 4'd0)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. Gated with preset_n so the bus sees quiet outputs while
    // reset is held, even if the initiator drives psel/penable.
    // ------------------------------------------------------------------------
    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'd0;
        if (preset_n) begin
            if (w_proto_err) begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end else if (w_done) begin
                pready  = 1'b1;
                pslverr = !r_valid;
                if (!r_write && r_valid) begin
                    prdata = w_rd_mux;
                end
            end
        end
    end

    assign reg_wr_o = r_wr_pulse;

    // ------------------------------------------------------------------------
    // Setup-phase capture and wait counter. paddr/pwrite are only looked at
    // here, so later changes during the access phase have no effect.
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_setup) begin
            r_cnt   <= c_WAIT;
            r_idx   <= w_dec_idx;
            r_write <= pwrite;
            r_valid <= w_dec_valid;
        end else if ((r_state == c_ST_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Register array and write strobe. The strobe is registered so it is high
    // for exactly the cycle after the edge that updates the register.
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= 32'd0;
            end
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_commit ? w_sel : '0;
            if (w_commit) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (w_sel[i]) begin
                        for (int k = 0; k < 4; k++) begin
                            if (w_be[k]) begin
                                r_regs[i][8*k +: 8] <= pwdata[8*k +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
